// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer.
// The master drives the in_* payload and out_ready; the slave is the result stage.
interface alu_result_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_s;
  logic        in_cout;
  logic [1:0]  in_select;
  logic        in_a15;
  logic        in_b15;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_s;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_s, in_cout, in_select, in_a15, in_b15, out_ready,
    input  in_ready, out_valid, out_s, out_flags
  );

  modport slave (
    input  in_valid, in_s, in_cout, in_select, in_a15, in_b15, out_ready,
    output in_ready, out_valid, out_s, out_flags
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: derives N/Z/C/V, buffers results in a 2-entry
// skid buffer behind a registered in_ready, and keeps sticky flags and a transfer count.
module alu_result_stage (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus,
  input  logic                clr,
  output logic [3:0]          sticky_flags,
  output logic [7:0]          xfer_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q, state_d;
  logic [15:0] main_s_q, main_s_d, skid_s_q, skid_s_d;
  logic [3:0]  main_flags_q, main_flags_d, skid_flags_q, skid_flags_d;
  logic        in_ready_q, in_ready_d;
  logic [3:0]  sticky_q, sticky_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        in_xfer, out_xfer;
  logic        flag_c, flag_v;
  logic [3:0]  in_flags;

  // C and V are only meaningful for the arithmetic selects.
  always_comb begin
    flag_c = 1'b0;
    flag_v = 1'b0;
    unique case (bus.in_select)
      2'd2: begin
        flag_c = bus.in_cout;
        flag_v = (bus.in_a15 == bus.in_b15) & (bus.in_s[15] != bus.in_a15);
      end
      2'd3: begin
        flag_c = bus.in_cout;
        flag_v = (bus.in_a15 != bus.in_b15) & (bus.in_s[15] != bus.in_a15);
      end
      default: begin
      end
    endcase
    in_flags = {bus.in_s[15], bus.in_s == 16'h0000, flag_c, flag_v};
  end

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = (state_q != StEmpty) & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    main_s_d     = main_s_q;
    main_flags_d = main_flags_q;
    skid_s_d     = skid_s_q;
    skid_flags_d = skid_flags_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_s_d     = bus.in_s;
          main_flags_d = in_flags;
          state_d      = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_s_d     = bus.in_s;
          main_flags_d = in_flags;
        end else if (in_xfer) begin
          skid_s_d     = bus.in_s;
          skid_flags_d = in_flags;
          state_d      = StTwo;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only a drain can happen.
        if (out_xfer) begin
          main_s_d     = skid_s_q;
          main_flags_d = skid_flags_q;
          state_d      = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StTwo);
  end

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr && out_xfer) begin
      sticky_d = main_flags_q;
      cnt_d    = 8'd1;
    end else if (clr) begin
      sticky_d = 4'h0;
      cnt_d    = 8'd0;
    end else if (out_xfer) begin
      sticky_d = sticky_q | main_flags_q;
      cnt_d    = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      main_s_q     <= 16'h0000;
      main_flags_q <= 4'h0;
      skid_s_q     <= 16'h0000;
      skid_flags_q <= 4'h0;
      in_ready_q   <= 1'b1;
      sticky_q     <= 4'h0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      main_s_q     <= main_s_d;
      main_flags_q <= main_flags_d;
      skid_s_q     <= skid_s_d;
      skid_flags_q <= skid_flags_d;
      in_ready_q   <= in_ready_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_s     = main_s_q;
  assign bus.out_flags = main_flags_q;
  assign sticky_flags  = sticky_q;
  assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue-based stress phase.
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] sticky_flags;
  logic [7:0] xfer_cnt;

  int n_vec;
  int n_err;

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clr          (clr),
    .sticky_flags (sticky_flags),
    .xfer_cnt     (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] s, input logic cout,
                       input logic [1:0] sel, input logic a15, input logic b15);
    bus.in_valid  = v;
    bus.in_s      = s;
    bus.in_cout   = cout;
    bus.in_select = sel;
    bus.in_a15    = a15;
    bus.in_b15    = b15;
  endtask

  function automatic logic [3:0] model_flags(input logic [15:0] s, input logic cout,
                                             input logic [1:0] sel, input logic a,
                                             input logic b);
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    if (sel == 2'd2) begin
      c = cout;
      v = (a == b) && (s[15] != a);
    end else if (sel == 2'd3) begin
      c = cout;
      v = (a != b) && (s[15] != a);
    end
    return {s[15], s == 16'h0000, c, v};
  endfunction

  initial begin
    logic [19:0] q[$];
    logic [19:0] e;
    int sent, got, cyc;

    n_vec = 0;
    n_err = 0;
    clr   = 1'b0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Reset values, both during reset and after release while idle.
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_s", 32'(bus.out_s), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Add overflow, held under back-pressure then drained.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h8000, 1'b0, 2'd2, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("add_ovf_valid", 32'(bus.out_valid), 32'd1);
    check("add_ovf_s", 32'(bus.out_s), 32'h8000);
    check("add_ovf_flags", 32'(bus.out_flags), 32'b1001);
    tick();
    check("add_ovf_hold", 32'(bus.out_s), 32'h8000);
    bus.out_ready = 1'b1;
    tick();
    check("add_ovf_drained", 32'(bus.out_valid), 32'd0);
    check("add_ovf_cnt", 32'(xfer_cnt), 32'd1);
    check("add_ovf_sticky", 32'(sticky_flags), 32'b1001);

    // Subtract to zero, then XOR to zero loaded in the same cycle main drains.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0000, 1'b1, 2'd3, 1'b1, 1'b1);
    tick();
    check("sub_zero_flags", 32'(bus.out_flags), 32'b0110);
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0000, 1'b1, 2'd1, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("xor_zero_valid", 32'(bus.out_valid), 32'd1);
    check("xor_zero_flags", 32'(bus.out_flags), 32'b0100);
    check("sticky_or", 32'(sticky_flags), 32'b1111);
    tick();
    check("xor_drained_cnt", 32'(xfer_cnt), 32'd3);
    check("xor_drained_valid", 32'(bus.out_valid), 32'd0);

    // Clear alone.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sticky", 32'(sticky_flags), 32'd0);
    check("clr_cnt", 32'(xfer_cnt), 32'd0);

    // Back-pressure: stream 1..6, out_ready drops from the second cycle.
    drive(1'b1, 16'd1, 1'b0, 2'd1, 1'b0, 1'b0);
    tick();
    check("bp_first", 32'(bus.out_s), 32'd1);
    bus.out_ready = 1'b0;
    bus.in_s = 16'd2;
    tick();
    bus.in_s = 16'd3;
    check("bp_skid_full", 32'(bus.in_ready), 32'd0);
    check("bp_head", 32'(bus.out_s), 32'd1);
    tick();
    tick();
    check("bp_still_full", 32'(bus.in_ready), 32'd0);
    check("bp_head_held", 32'(bus.out_s), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_s", 32'(bus.out_s), 32'd2);
    check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
    for (int k = 3; k <= 6; k++) begin
      bus.in_s = 16'(k);
      tick();
      check("bp_order_valid", 32'(bus.out_valid), 32'd1);
      check("bp_order_s", 32'(bus.out_s), 32'(k));
    end
    bus.in_valid = 1'b0;
    tick();
    check("bp_done_valid", 32'(bus.out_valid), 32'd0);
    check("bp_cnt", 32'(xfer_cnt), 32'd6);

    // Reset asserted while both entries are occupied.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1234, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("two_before_rst", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_s", 32'(bus.out_s), 32'd0);
    check("midrst_cnt", 32'(xfer_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("post_rst_empty", 32'(bus.out_valid), 32'd0);

    // Random stress with a queue scoreboard.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 1000 && cyc < 20000) begin
      drive((sent < 1000) && ($urandom_range(3) != 0), 16'($urandom), 1'($urandom),
            2'($urandom_range(3)), 1'($urandom), 1'($urandom));
      bus.out_ready = ($urandom_range(2) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("stress_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("stress_s", 32'(bus.out_s), 32'(e[19:4]));
          check("stress_flags", 32'(bus.out_flags), 32'(e[3:0]));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({bus.in_s, model_flags(bus.in_s, bus.in_cout, bus.in_select,
                                           bus.in_a15, bus.in_b15)});
        sent++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stress_count", 32'(got), 32'd1000);
    check("stress_xfer_cnt", 32'(xfer_cnt), 32'd232);
    tick();
    check("stress_empty", 32'(bus.out_valid), 32'd0);

    // 256 transfers wrap the counter; clr with a transfer reloads sticky/count.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(1'b1, 16'h8000, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++) tick();
    bus.in_valid = 1'b0;
    tick();
    check("wrap_cnt", 32'(xfer_cnt), 32'd0);
    check("wrap_sticky", 32'(sticky_flags), 32'b1000);
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0000, 1'b0, 2'd1, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("clr_xfer_flags", 32'(bus.out_flags), 32'b0100);
    clr = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_xfer_sticky", 32'(sticky_flags), 32'b0100);
    check("clr_xfer_cnt", 32'(xfer_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
